sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream feeder for the AXI-lite SHA-256 core. Accepts a raw message as a 32-bit AXI-Stream byte stream and emits fully padded 512-bit SHA-256 blocks as a stream of 16 words. The padding inserts the 0x80 terminator, zero fill and the 64-bit big-endian bit length. Each output word is packed exactly as the core's block registers 0x10–0x1f expect, so a loader can write word i of a block to register 0x10+i unchanged.

## Interface
- LEN_W, default 61: width of the internal byte counter; bit length = {byte_count, 3'b000}, zero-extended to 64 bits.
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-high.
- s_tdata  in  32  message bytes; byte k in bits [8k+7:8k].
- s_tkeep  in  4  byte valid, contiguous from bit 0. Must be 4'b1111 except on the tlast beat, where 4'b0000 (empty tail) is legal.
- s_tlast  in  1  last beat of message.
- s_tvalid / s_tready  in / out  1  input handshake.
- m_tdata  out  32  padded block word.
- m_tlast  out  1  word 15 of a block.
- m_tfinal  out  1  word belongs to the message's final block.
- m_tvalid / m_tready  out / in  1  output handshake.

## Operation
- States: DATA, PAD80, ZERO, LEN_HI, LEN_LO. A 4-bit word index wraps 15→0 on every output transfer.
- DATA: forward each accepted input word, and add popcount(tkeep) to byte_cnt.
- tlast beat with n = popcount(tkeep):
  - n < 4: output = data bytes, 0x80 in byte n, upper bytes 0.
  - n = 4: output data, then go to PAD80, which emits 0x00000080.
- After the 0x80 word is emitted at index i:
  - i ≤ 13: ZERO until index 14.
  - i ≥ 14: ZERO through index 15, then a further full block of ZERO up to index 14.
- LEN_HI emits bswap32(len[63:32]) at index 14. LEN_LO emits bswap32(len[31:0]) at index 15.
- After LEN_LO is accepted: clear byte_cnt and the index, return to DATA.
- m_tfinal is 1 on all words of the block containing LEN_HI/LEN_LO. The padder sets it when it enters that block: it knows the block is final once tlast is seen and the 0x80 index is ≤ 13, or when the extra zero block starts.
- s_tready is 0 in every state except DATA.
- byte_cnt wraps modulo 2^LEN_W. Behaviour is unspecified for messages of 2^LEN_W bytes or more.

## Timing
- Single output register stage. An accepted input word appears on m_tdata the next cycle.
- s_tready = (state==DATA) && (!m_tvalid || m_tready). Sustained 1 word/cycle with no stalls in DATA.
- Pad and length words are generated 1 per cycle whenever m_tready=1. Input stalls during generation.
- m_tdata, m_tlast and m_tfinal are held stable while m_tvalid && !m_tready.
- Minimum gap between the last output word of message N and the first output word of message N+1: 1 cycle.
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, m_tfinal=0, s_tready=0 while reset is asserted. State=DATA, index=0, byte_cnt=0.
- Reset mid-message drops the in-flight word and all counters. The next message starts clean at index 0.
- Simultaneous output accept and input accept in the same cycle is legal. The output register loads the new word.

## Structure
- The shared sha256 package holds:
  - the state enum;
  - PAD_BYTE = 8'h80;
  - LEN_HI_IDX = 4'd14 and LEN_LO_IDX = 4'd15;
  - a bswap32 function.
- One sub-module, sha256_pad_word: combinational tail-word builder (data, n → padded word). It is shared with the verification model.

## Test plan
- "hello world" (11 bytes: 0x6c6c6568, 0x6f77206f, tkeep=0111 0x00646c72 with tlast) → 16 words: 0x6c6c6568, 0x6f77206f, 0x80646c72, 0×12, 0x58000000. m_tlast on word 15, m_tfinal on all 16 words.
- Empty message (single beat, tkeep=0000, tlast) → 0x00000080, then 15 zero words (word 15 = 0, length 0). One block.
- 56-byte message (14 full beats) → block 1: data + 0x00000080 at index 14 + 0 at index 15, m_tfinal=0. Block 2: 14 zeros, 0x00000000, 0xc0010000. Block 2 has m_tfinal=1.
- 64-byte message → block 1 = data. Block 2: 0x00000080, 13 zeros, 0x00000000, 0x00020000.
- Random m_tready backpressure (50%) plus s_tvalid gaps on the "hello world" case → identical word sequence, m_tdata held stable while stalled, no lost or duplicated words. Then reset asserted mid-message → m_tvalid=0 in the same cycle, and the next message's output matches a clean run.

Source files
------------

// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM states, pad constants
// and byte helpers used by the padder and its tail-word builder.
package sha256_msg_padder_pkg;

    typedef enum logic [2:0] {
        ST_DATA,
        ST_PAD80,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } pad_state_t;

    localparam logic [7:0] PAD_BYTE   = 8'h80;
    localparam logic [3:0] LEN_HI_IDX = 4'd14;
    localparam logic [3:0] LEN_LO_IDX = 4'd15;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // tkeep is contiguous from bit 0, so only these five patterns occur
    function automatic logic [2:0] keep_count(input logic [3:0] k);
        case (k)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            4'b1111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Tail-word builder: keeps the low n message bytes, places 0x80 in byte n and
// zeroes everything above it. n = 4 passes the word through unchanged.
module sha256_pad_word
    import sha256_msg_padder_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_nbytes,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < 32'(i_nbytes))
                o_word[8*k +: 8] = i_data[8*k +: 8];
            else if (k == 32'(i_nbytes))
                o_word[8*k +: 8] = PAD_BYTE;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Converts a 32-bit AXI-Stream byte stream into padded 512-bit SHA-256 blocks,
// emitted as 16-word bursts in the core's block-register word layout.
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
#(
    parameter int unsigned LEN_W = 61
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tfinal,
    output logic        m_tvalid,
    input  logic        m_tready
);

    localparam logic [3:0] IDX_PRE = LEN_HI_IDX - 4'd1;

    pad_state_t       r_state, w_state_nxt;
    logic [3:0]       r_idx;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_fblk, w_fblk_nxt;
    logic [31:0]      r_tdata;
    logic             r_tlast, r_tfinal, r_tvalid;

    logic        w_out_free;
    logic        w_ld;
    logic [31:0] w_word;
    logic        w_fin;
    logic [2:0]  w_nbytes;
    logic [31:0] w_padded;
    logic [63:0] w_len;

    assign w_out_free = !r_tvalid || m_tready;
    assign w_nbytes   = keep_count(s_tkeep);
    assign w_len      = 64'({r_cnt, 3'b000});

    sha256_pad_word u_pad_word (
        .i_data   (s_tdata),
        .i_nbytes (w_nbytes),
        .o_word   (w_padded)
    );

    // r_fblk marks the block currently being emitted as the one carrying the length
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fblk_nxt  = r_fblk;
        w_ld        = 1'b0;
        w_word      = '0;
        w_fin       = 1'b0;
        if (w_out_free) begin
            case (r_state)
                ST_DATA: begin
                    if (s_tvalid) begin
                        w_ld      = 1'b1;
                        w_cnt_nxt = r_cnt + LEN_W'(w_nbytes);
                        if (!s_tlast) begin
                            w_word = s_tdata;
                        end else if (w_nbytes == 3'd4) begin
                            w_word      = s_tdata;
                            w_fin       = (r_idx < IDX_PRE);
                            w_fblk_nxt  = w_fin;
                            w_state_nxt = ST_PAD80;
                        end else begin
                            w_word      = w_padded;
                            w_fin       = (r_idx <= IDX_PRE);
                            w_fblk_nxt  = w_fin;
                            w_state_nxt = (r_idx == IDX_PRE) ? ST_LEN_HI : ST_ZERO;
                        end
                    end
                end
                ST_PAD80: begin
                    w_ld        = 1'b1;
                    w_word      = {24'h0, PAD_BYTE};
                    w_fin       = (r_idx <= IDX_PRE);
                    w_fblk_nxt  = w_fin;
                    w_state_nxt = (r_idx == IDX_PRE) ? ST_LEN_HI : ST_ZERO;
                end
                ST_ZERO: begin
                    // wrapping to index 0 here means the extra, final block has begun
                    w_ld        = 1'b1;
                    w_fin       = r_fblk || (r_idx == 4'd0);
                    w_fblk_nxt  = w_fin;
                    w_state_nxt = (r_idx == IDX_PRE) ? ST_LEN_HI : ST_ZERO;
                end
                ST_LEN_HI: begin
                    w_ld        = 1'b1;
                    w_word      = bswap32(w_len[63:32]);
                    w_fin       = 1'b1;
                    w_state_nxt = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    w_ld        = 1'b1;
                    w_word      = bswap32(w_len[31:0]);
                    w_fin       = 1'b1;
                    w_fblk_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
                default: w_state_nxt = ST_DATA;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_state  <= ST_DATA;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_fblk   <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tfinal <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fblk  <= w_fblk_nxt;
            if (w_out_free)
                r_tvalid <= w_ld;
            if (w_ld) begin
                r_idx    <= r_idx + 4'd1;
                r_tdata  <= w_word;
                r_tlast  <= (r_idx == LEN_LO_IDX);
                r_tfinal <= w_fin;
            end
        end
    end

    assign s_tready = !aresetn && (r_state == ST_DATA) && w_out_free;
    assign m_tdata  = r_tdata;
    assign m_tlast  = r_tlast;
    assign m_tfinal = r_tfinal;
    assign m_tvalid = r_tvalid;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks for several
// message lengths, backpressure/gap stress and mid-message reset.
module tb_sha256_msg_padder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tfinal;
    logic        m_tvalid;
    logic        m_tready = 1'b0;

    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    logic [31:0] in_d[$];
    logic [3:0]  in_k[$];
    logic        in_l[$];
    logic [31:0] ex_d[$];
    logic        ex_f[$];
    bit          ex_fc[$];

    always #5 aclk = ~aclk;

    sha256_msg_padder #(.LEN_W(61)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tfinal (m_tfinal),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add_in(input logic [31:0] d, input logic [3:0] k, input logic l);
        in_d.push_back(d);
        in_k.push_back(k);
        in_l.push_back(l);
    endtask

    task automatic add_ex(input logic [31:0] d, input logic f, input bit fc);
        ex_d.push_back(d);
        ex_f.push_back(f);
        ex_fc.push_back(fc);
    endtask

    task automatic add_zeros(input int n, input logic f);
        for (int i = 0; i < n; i++) add_ex(32'h0, f, 1'b1);
    endtask

    task automatic drive(input bit gaps);
        for (int b = 0; b < in_d.size(); b++) begin
            int wait_cyc;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    @(negedge aclk);
                    s_tvalid = 1'b0;
                end
            end
            @(negedge aclk);
            s_tvalid = 1'b1;
            s_tdata  = in_d[b];
            s_tkeep  = in_k[b];
            s_tlast  = in_l[b];
            #1;
            wait_cyc = 0;
            while (!s_tready && wait_cyc < 1000) begin
                @(negedge aclk);
                #1;
                wait_cyc++;
            end
            if (wait_cyc >= 1000) begin
                chk("drive timeout", 64'(b), 64'(in_d.size()));
                break;
            end
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic collect(input string name, input bit stress);
        int got, cyc, first, lastc;
        bit stall;
        logic [33:0] held;
        got = 0; cyc = 0; first = -1; lastc = 0; stall = 0; held = '0;
        while (got < ex_d.size() && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            m_tready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall)
                chk({name, " hold"}, {m_tvalid, m_tdata, m_tlast, m_tfinal}, {1'b1, held});
            if (m_tvalid && m_tready) begin
                chk($sformatf("%s w%0d data", name, got), m_tdata, ex_d[got]);
                chk($sformatf("%s w%0d last", name, got), m_tlast, (got % 16 == 15));
                if (ex_fc[got])
                    chk($sformatf("%s w%0d final", name, got), m_tfinal, ex_f[got]);
                if (first < 0) first = cyc;
                lastc = cyc;
                got++;
            end
            stall = m_tvalid && !m_tready;
            held  = {m_tdata, m_tlast, m_tfinal};
        end
        chk({name, " count"}, 64'(got), 64'(ex_d.size()));
        if (!stress)
            chk({name, " span"}, 64'(lastc - first), 64'(ex_d.size() - 1));
        @(negedge aclk);
        m_tready = 1'b1;
        #1;
        chk({name, " idle"}, m_tvalid, 1'b0);
    endtask

    task automatic run_case(input string name, input bit stress);
        fork
            drive(stress);
            collect(name, stress);
        join
        in_d.delete(); in_k.delete(); in_l.delete();
        ex_d.delete(); ex_f.delete(); ex_fc.delete();
    endtask

    // "hello world": tfinal cannot be known on words emitted before tlast
    task automatic load_hello();
        add_in(32'h6c6c6568, 4'b1111, 1'b0);
        add_in(32'h6f77206f, 4'b1111, 1'b0);
        add_in(32'h00646c72, 4'b0111, 1'b1);
        add_ex(32'h6c6c6568, 1'b1, 1'b0);
        add_ex(32'h6f77206f, 1'b1, 1'b0);
        add_ex(32'h80646c72, 1'b1, 1'b1);
        add_zeros(12, 1'b1);
        add_ex(32'h58000000, 1'b1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst m_tvalid", m_tvalid, 1'b0);
        chk("rst m_tdata", m_tdata, 32'h0);
        chk("rst m_tlast", m_tlast, 1'b0);
        chk("rst m_tfinal", m_tfinal, 1'b0);
        chk("rst s_tready", s_tready, 1'b0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b0;
        m_tready = 1'b1;

        load_hello();
        run_case("hello", 1'b0);

        add_in(32'h0, 4'b0000, 1'b1);
        add_ex(32'h00000080, 1'b1, 1'b1);
        add_zeros(15, 1'b1);
        run_case("empty", 1'b0);

        for (int i = 0; i < 14; i++) begin
            logic [31:0] w;
            w = 32'h03020100 + 32'(i) * 32'h04040404;
            add_in(w, 4'b1111, i == 13);
            add_ex(w, 1'b0, 1'b1);
        end
        add_ex(32'h00000080, 1'b0, 1'b1);
        add_ex(32'h0, 1'b0, 1'b1);
        add_zeros(15, 1'b1);
        add_ex(32'hc0010000, 1'b1, 1'b1);
        run_case("b56", 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = 32'ha0b0c0d0 ^ 32'(i * 32'h01010101);
            add_in(w, 4'b1111, i == 15);
            add_ex(w, 1'b0, 1'b1);
        end
        add_ex(32'h00000080, 1'b1, 1'b1);
        add_zeros(14, 1'b1);
        add_ex(32'h00020000, 1'b1, 1'b1);
        run_case("b64", 1'b0);

        add_in(32'h64636261, 4'b1111, 1'b0);
        add_in(32'hdead6665, 4'b0011, 1'b1);
        add_ex(32'h64636261, 1'b1, 1'b0);
        add_ex(32'h00806665, 1'b1, 1'b1);
        add_zeros(13, 1'b1);
        add_ex(32'h30000000, 1'b1, 1'b1);
        run_case("b6", 1'b0);

        load_hello();
        run_case("hello_stress", 1'b1);

        // park two words in flight with the output stalled, then reset
        @(negedge aclk);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h6c6c6568;
        s_tkeep  = 4'b1111;
        s_tlast  = 1'b0;
        @(negedge aclk);
        s_tdata  = 32'h6f77206f;
        #1;
        chk("pre-rst m_tvalid", m_tvalid, 1'b1);
        chk("pre-rst s_tready", s_tready, 1'b0);
        aresetn = 1'b1;
        #1;
        chk("mid-rst m_tvalid", m_tvalid, 1'b0);
        chk("mid-rst m_tdata", m_tdata, 32'h0);
        chk("mid-rst m_tfinal", m_tfinal, 1'b0);
        chk("mid-rst s_tready", s_tready, 1'b0);
        s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        m_tready = 1'b1;

        load_hello();
        run_case("hello_after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
